hilo_ctrl: RTL

Sequencing and register stage between the integer pipeline and the serial multiplier/divider. Accepts mult/div issues, launches the serial unit with a one-cycle start pulse and held operands, waits for completion, and captures the 64-bit result into the architectural HI/LO registers. Also serves mfhi/mflo/mthi/mtlo, stalling the pipeline while an operation is in flight.

---
 rtl/hilo_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO register stage and sequencer for the serial multiplier/divider.
// Launches one operation at a time and stalls pipeline requests while it is in flight.
module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_multdivb,
    input  logic        op_signed,
    input  logic [31:0] op_x,
    input  logic [31:0] op_y,
    input  logic        mf_req,
    input  logic        mt_we,
    input  logic        hl_sel,
    input  logic [31:0] mt_data,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        busy,
    output logic        dbz,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_start,
    output logic        md_multdivb,
    output logic        md_signed,
    output logic [31:0] md_x,
    output logic [31:0] md_y,
    input  logic [31:0] md_prodh,
    input  logic [31:0] md_prodl,
    input  logic        md_run,
    input  logic        md_dividebyzero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;
    logic [31:0] md_x_q, md_x_d;
    logic [31:0] md_y_q, md_y_d;
    logic        md_multdivb_q, md_multdivb_d;
    logic        md_signed_q, md_signed_d;
    logic        md_start_q, md_start_d;

    // Next-state and register update logic
    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        dbz_d         = dbz_q;
        md_x_d        = md_x_q;
        md_y_d        = md_y_q;
        md_multdivb_d = md_multdivb_q;
        md_signed_d   = md_signed_q;
        md_start_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // mt write lands now; a simultaneously accepted op overwrites HI/LO later
                if (mt_we) begin
                    if (hl_sel) begin
                        hi_d = mt_data;
                    end else begin
                        lo_d = mt_data;
                    end
                end else begin
                    hi_d = hi_q;
                end
                if (op_valid) begin
                    md_x_d        = op_x;
                    md_y_d        = op_y;
                    md_multdivb_d = op_multdivb;
                    md_signed_d   = op_signed;
                    dbz_d         = 1'b0;
                    md_start_d    = 1'b1;
                    state_d       = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (!md_run) begin
                    hi_d    = md_prodh;
                    lo_d    = md_prodl;
                    dbz_d   = md_dividebyzero & ~md_multdivb_q;
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hi_q          <= 32'h0000_0000;
            lo_q          <= 32'h0000_0000;
            dbz_q         <= 1'b0;
            md_x_q        <= 32'h0000_0000;
            md_y_q        <= 32'h0000_0000;
            md_multdivb_q <= 1'b0;
            md_signed_q   <= 1'b0;
            md_start_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            dbz_q         <= dbz_d;
            md_x_q        <= md_x_d;
            md_y_q        <= md_y_d;
            md_multdivb_q <= md_multdivb_d;
            md_signed_q   <= md_signed_d;
            md_start_q    <= md_start_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign stall       = busy & (op_valid | mf_req | mt_we);
    assign mf_data     = hl_sel ? hi_q : lo_q;
    assign dbz         = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign md_start    = md_start_q;
    assign md_multdivb = md_multdivb_q;
    assign md_signed   = md_signed_q;
    assign md_x        = md_x_q;
    assign md_y        = md_y_q;

endmodule
